// File: rtl/riscv_retire_monitor.sv
`default_nettype none
// ============================================================================
// Module      : riscv_retire_monitor
// Description : Observes retiring instructions and produces the retired count,
//               the last result value and a sticky halt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_retire_monitor #(
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] HALT_PREV = 32'h00c00093,
    parameter logic [31:0] HALT_INST = 32'h00008067
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RET_VALID,
    input  logic [31:0]          RET_INST,
    input  logic                 RET_RF_WE,
    input  logic [4:0]           RET_RF_WA,
    input  logic [31:0]          RET_RF_WD,
    input  logic                 RET_IS_STORE,
    input  logic [11:0]          RET_MEM_ADDR,
    input  logic                 RET_IS_BRANCH,
    input  logic                 RET_BR_TAKEN,
    output logic [CNT_WIDTH-1:0] NUM_INST,
    output logic [31:0]          OUTPUT_PORT,
    output logic                 HALT
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_num_inst;
    logic [31:0]            r_output;
    logic                   w_active;
    logic                   w_out_upd;
    logic [31:0]            w_out_nxt;

    // Once halted, nothing retired afterwards is architecturally visible.
    assign w_active = RET_VALID && (r_state != ST_HALTED);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_num_inst <= '0;
            r_output   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_active) begin
                r_num_inst <= r_num_inst + c_cnt_one;
            end
            if (w_out_upd) begin
                r_output <= w_out_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (RET_VALID && (RET_INST == HALT_PREV)) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Bubbles between the two halt words keep the FSM armed.
                if (RET_VALID) begin
                    if (RET_INST == HALT_INST) begin
                        w_state_nxt = ST_HALTED;
                    end else if (RET_INST != HALT_PREV) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_out_upd = 1'b0;
        w_out_nxt = r_output;
        if (w_active) begin
            if (RET_IS_STORE) begin
                w_out_upd = 1'b1;
                w_out_nxt = {20'b0, RET_MEM_ADDR};
            end else if (RET_IS_BRANCH) begin
                w_out_upd = 1'b1;
                w_out_nxt = {31'b0, RET_BR_TAKEN};
            end else if (RET_RF_WE) begin
                // Writes to x0 report zero since x0 never changes.
                w_out_upd = 1'b1;
                w_out_nxt = (RET_RF_WA != 5'd0) ? RET_RF_WD : 32'd0;
            end
        end
    end

    assign NUM_INST    = r_num_inst;
    assign OUTPUT_PORT = r_output;
    assign HALT        = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_riscv_retire_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_retire_monitor
// Description : Table-driven self-checking bench for riscv_retire_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_retire_monitor;

    localparam logic [31:0] c_prev  = 32'h00c00093;
    localparam logic [31:0] c_jalr  = 32'h00008067;
    localparam logic [31:0] c_other = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        RET_VALID;
    logic [31:0] RET_INST;
    logic        RET_RF_WE;
    logic [4:0]  RET_RF_WA;
    logic [31:0] RET_RF_WD;
    logic        RET_IS_STORE;
    logic [11:0] RET_MEM_ADDR;
    logic        RET_IS_BRANCH;
    logic        RET_BR_TAKEN;
    logic [31:0] NUM_INST;
    logic [31:0] OUTPUT_PORT;
    logic        HALT;
    logic [3:0]  NUM_NARROW;
    logic [31:0] OUT_NARROW;
    logic        HALT_NARROW;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    riscv_retire_monitor dut (
        .CLK(CLK), .RSTn(RSTn), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
        .RET_RF_WE(RET_RF_WE), .RET_RF_WA(RET_RF_WA), .RET_RF_WD(RET_RF_WD),
        .RET_IS_STORE(RET_IS_STORE), .RET_MEM_ADDR(RET_MEM_ADDR),
        .RET_IS_BRANCH(RET_IS_BRANCH), .RET_BR_TAKEN(RET_BR_TAKEN),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT)
    );

    // Narrow-counter copy so modular wrap is reachable in a short run.
    riscv_retire_monitor #(.CNT_WIDTH(4)) dut_narrow (
        .CLK(CLK), .RSTn(RSTn), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
        .RET_RF_WE(RET_RF_WE), .RET_RF_WA(RET_RF_WA), .RET_RF_WD(RET_RF_WD),
        .RET_IS_STORE(RET_IS_STORE), .RET_MEM_ADDR(RET_MEM_ADDR),
        .RET_IS_BRANCH(RET_IS_BRANCH), .RET_BR_TAKEN(RET_BR_TAKEN),
        .NUM_INST(NUM_NARROW), .OUTPUT_PORT(OUT_NARROW), .HALT(HALT_NARROW)
    );

    typedef struct {
        logic        rstn;
        logic        valid;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic [11:0] addr;
        logic        br;
        logic        tk;
        logic [31:0] e_num;
        logic [31:0] e_out;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rstn, logic valid, logic [31:0] inst,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic st, logic [11:0] addr, logic br, logic tk,
                                logic [31:0] e_num, logic [31:0] e_out, logic e_halt);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.inst = inst; v.we = we; v.wa = wa;
        v.wd = wd; v.st = st; v.addr = addr; v.br = br; v.tk = tk;
        v.e_num = e_num; v.e_out = e_out; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge CLK);
        RSTn = v.rstn; RET_VALID = v.valid; RET_INST = v.inst;
        RET_RF_WE = v.we; RET_RF_WA = v.wa; RET_RF_WD = v.wd;
        RET_IS_STORE = v.st; RET_MEM_ADDR = v.addr;
        RET_IS_BRANCH = v.br; RET_BR_TAKEN = v.tk;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    initial begin
        // rstn valid inst we wa wd st addr br tk | num out halt
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_other, 0, 0, 0, 1, 12'h010, 0, 0, 1, 32'h10, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 5, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 6, 5, 0, 0, 0, 0, 3, 5, 0));
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 7, 32'hF, 0, 0, 0, 0, 1, 32'hF, 0));
        vecs.push_back(mk(1, 0, c_other, 1, 9, 32'h55, 1, 12'h3, 0, 0, 1, 32'hF, 0));
        vecs.push_back(mk(1, 0, c_prev, 1, 9, 32'h66, 0, 0, 1, 1, 1, 32'hF, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 8, 32'h1E, 0, 0, 0, 0, 2, 32'h1E, 0));
        vecs.push_back(mk(1, 1, c_other, 0, 0, 0, 0, 0, 1, 1, 3, 1, 0));
        vecs.push_back(mk(1, 1, c_other, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 0, 32'hDEAD, 0, 0, 0, 0, 5, 0, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 3, 32'h99, 1, 12'h7FF, 1, 1, 6, 32'h7FF, 0));
        vecs.push_back(mk(1, 1, c_other, 0, 4, 32'h44, 0, 0, 0, 0, 7, 32'h7FF, 0));
        vecs.push_back(mk(1, 1, c_other, 0, 0, 0, 0, 0, 1, 1, 8, 1, 0));
        // halt sequence, then frozen outputs
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_prev, 1, 1, 12, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 2, 0, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 1, c_other, 1, 6, 9, 0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(1, 1, c_prev, 0, 0, 0, 1, 12'h123, 0, 0, 2, 0, 1));
        // interrupted sequence does not halt
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_prev, 1, 1, 12, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(1, 1, c_other, 1, 3, 7, 0, 0, 0, 0, 2, 7, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 4, 0, 0));
        // bubbles between halt words keep it armed
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_prev, 1, 1, 12, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(1, 0, c_other, 1, 2, 3, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(1, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 2, 0, 1));
        // repeated first word stays armed
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_prev, 1, 1, 12, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(1, 1, c_prev, 1, 1, 12, 0, 0, 0, 0, 2, 12, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 3, 0, 1));
        // reset while halted with NUM_INST=7 and an active retire
        vecs.push_back(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(1, 1, c_other, 1, 6, 9, 0, 0, 0, 0, 32'(i), 9, 0));
        vecs.push_back(mk(1, 1, c_prev, 1, 1, 12, 0, 0, 0, 0, 6, 12, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 7, 0, 1));
        vecs.push_back(mk(0, 1, c_prev, 1, 6, 9, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, c_jalr, 1, 0, 32'h8, 0, 0, 0, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check($sformatf("v%0d NUM_INST", i), NUM_INST, vecs[i].e_num);
            check($sformatf("v%0d OUTPUT_PORT", i), OUTPUT_PORT, vecs[i].e_out);
            check($sformatf("v%0d HALT", i), {31'b0, HALT}, {31'b0, vecs[i].e_halt});
        end

        // counter wrap on the 4-bit instance: 15 retires then one more
        drive(mk(0, 0, c_other, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("wrap reset", {28'b0, NUM_NARROW}, 32'd0);
        for (int i = 1; i <= 15; i++)
            drive(mk(1, 1, c_other, 1, 6, 32'(i), 0, 0, 0, 0, 0, 0, 0));
        check("wrap max", {28'b0, NUM_NARROW}, 32'd15);
        check("wide at 15", NUM_INST, 32'd15);
        drive(mk(1, 1, c_other, 1, 6, 32'h77, 0, 0, 0, 0, 0, 0, 0));
        check("wrap zero", {28'b0, NUM_NARROW}, 32'd0);
        check("wide no wrap", NUM_INST, 32'd16);
        check("wrap out", OUT_NARROW, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_retire_monitor.md
Name: riscv_retire_monitor

Overview:
- Sits inside the single-cycle CPU top. It observes each retiring instruction and produces the three architectural status outputs the bench checks.
- NUM_INST is the retired-instruction count.
- OUTPUT_PORT is the per-instruction result value.
- HALT is the program-end flag, raised on the halt sequence.
- It is purely observational: it never stalls or alters the datapath.

Parameters:
- CNT_WIDTH, 32, width of the NUM_INST counter.
- HALT_PREV, 32'h00c00093, first word of the halt sequence (addi x1,x0,12).
- HALT_INST, 32'h00008067, second word of the halt sequence (jalr x0,0(x1)).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- RET_VALID  in  1  an instruction retires this cycle.
- RET_INST  in  32  encoding of the retiring instruction.
- RET_RF_WE  in  1  retiring instruction writes the register file.
- RET_RF_WA  in  5  destination register.
- RET_RF_WD  in  32  write-back data.
- RET_IS_STORE  in  1  retiring instruction is a store.
- RET_MEM_ADDR  in  12  store effective byte address.
- RET_IS_BRANCH  in  1  retiring instruction is a conditional branch.
- RET_BR_TAKEN  in  1  branch outcome.
- NUM_INST  out  CNT_WIDTH  count of retired instructions (registered).
- OUTPUT_PORT  out  32  result of the last retired instruction (registered).
- HALT  out  1  halt detected; sticky until reset (registered).

Behaviour:
- Reset: on a rising CLK edge with RSTn=0, NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE. RSTn=0 mid-program overrides every other input on that edge.
- All outputs are registers with 1-cycle latency. After the edge on which the k-th RET_VALID is sampled, NUM_INST=k and OUTPUT_PORT holds the k-th instruction's result on the same cycle.
- Counter:
  - +1 per edge with RET_VALID=1 while the FSM is not HALTED.
  - Wraps modulo 2^CNT_WIDTH; no saturation.
- OUTPUT_PORT update, only when RET_VALID=1 and not HALTED. Priority order:
  1. RET_IS_STORE: {20'b0, RET_MEM_ADDR}.
  2. else RET_IS_BRANCH: {31'b0, RET_BR_TAKEN}.
  3. else RET_RF_WE and RET_RF_WA!=0: RET_RF_WD.
  4. else RET_RF_WE and RET_RF_WA==0: 0 (x0 stays architecturally zero).
  5. else: hold the previous value.
- OUTPUT_PORT holds whenever RET_VALID=0.
- Halt FSM (transitions only on RET_VALID=1):
  - IDLE: RET_INST==HALT_PREV -> ARMED; otherwise stay.
  - ARMED: RET_INST==HALT_INST -> HALTED. RET_INST==HALT_PREV -> stay ARMED. Any other instruction -> IDLE.
  - HALTED: absorbing; HALT=1. Only reset leaves this state.
  - RET_VALID=0 cycles between the two halt words do not disarm the FSM.
- Edge into HALTED: the halting jalr itself is counted (NUM_INST increments) and its OUTPUT_PORT rule applies (rf write to x0 -> 0). HALT rises on that same edge.
- In HALTED: NUM_INST, OUTPUT_PORT and HALT are frozen regardless of RET_* inputs.
- Simultaneous RET_IS_STORE and RET_IS_BRANCH is illegal from the decoder. The defined priority (store wins) still applies.

Test Plan:
- Reset, then 3 retires: sw addr 12'h010, lw x5 = 0, addi x6 = 5. Required: NUM_INST 1,2,3 on successive cycles; OUTPUT_PORT 0x10, 0x0, 0x5.
- RET_VALID toggled 1,0,0,1 with addi x7 = 0xF, then addi x8 = 0x1E. Required: NUM_INST = 1,1,1,2; OUTPUT_PORT holds 0xF through the idle cycles, then 0x1E.
- Branch taken followed by branch not-taken, plus one rf write to x0 with WD=0xDEAD. Required: OUTPUT_PORT 1, 0, 0.
- Retire 0x00c00093, then 0x00008067. Required: HALT=1 after the second edge and NUM_INST=2. Then 5 more retires of addi x6 = 9: all outputs frozen.
- Retire 0x00c00093, an add, then 0x00008067. Required: HALT stays 0 and NUM_INST=3. Separately, 0x00c00093, two RET_VALID=0 cycles, then 0x00008067: HALT=1.
- RSTn=0 for one edge after NUM_INST=7 with HALT=1 and RET_VALID=1. Required: all outputs 0 and FSM IDLE. Preload the counter to 2^32-1 via retires (force in sim) and retire once: NUM_INST wraps to 0.
